// File: rtl/game_pkg.sv
// Shared types for the 1A2B game blocks: BCD digits, 4-digit guesses,
// guess/score history entries and the auto-guesser state encoding.
package game_pkg;

  localparam int MAX_DIGIT = 9;

  typedef logic [3:0] digit_t;
  typedef digit_t [3:0] guess_t;

  typedef struct packed {
    guess_t     g;
    logic [2:0] a;
    logic [2:0] b;
  } hist_entry_t;

  typedef enum logic [2:0] {IDLE, NEXT, CHECK, OFFER, WAIT_FB, SOLVED, FAIL} auto_state_t;

  function automatic logic digits_distinct(input guess_t g);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (g[i] == g[j]) ok = 1'b0;
    return ok;
  endfunction

  // Decimal increment; bit 16 of the result is the carry out of 9999.
  function automatic logic [16:0] bcd_inc(input guess_t g);
    guess_t r;
    logic   c;
    r = g;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i] == digit_t'(MAX_DIGIT)) begin
          r[i] = '0;
        end else begin
          r[i] = r[i] + 4'd1;
          c    = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/calc_ab.sv
// Combinational 1A2B scorer: A = same digit in same position,
// B = digit present in the other number at a different position.
module Calc_AB
  import game_pkg::*;
(
  input  guess_t     secret,
  input  guess_t     guess,
  output logic [2:0] a,
  output logic [2:0] b
);

  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (secret[i] == guess[j]) begin
          if (i == j) a = a + 3'd1;
          else        b = b + 3'd1;
        end
  end

endmodule

// File: rtl/auto_guesser.sv
// 1A2B machine guesser: walks candidates in ascending order and offers the
// first one consistent with every recorded guess/score pair.
module auto_guesser
  import game_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TW    = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          start,
  output guess_t        guess,
  output logic          guess_valid,
  input  logic          guess_ready,
  input  logic          fb_valid,
  input  logic [2:0]    fb_a,
  input  logic [2:0]    fb_b,
  output logic          busy,
  output logic          solved,
  output logic          fail,
  output logic [TW-1:0] turn_count
);

  auto_state_t                   state_q, state_d;
  guess_t                        cand_q, cand_d;
  guess_t                        guess_q, guess_d;
  logic                          rej_q, rej_d;
  logic [TW-1:0]                 idx_q, idx_d;
  logic [TW-1:0]                 cnt_q, cnt_d;
  logic [TW-1:0]                 turn_q, turn_d;
  hist_entry_t [DEPTH-1:0]       hist_q, hist_d;

  hist_entry_t hist_sel;
  logic [2:0]  calc_a, calc_b;
  logic [16:0] inc;
  logic        fb_bad;

  always_comb begin
    hist_sel = '0;
    for (int i = 0; i < DEPTH; i++)
      if (idx_q == TW'(i)) hist_sel = hist_q[i];
  end

  Calc_AB u_calc (
    .secret (hist_sel.g),
    .guess  (cand_q),
    .a      (calc_a),
    .b      (calc_b)
  );

  // 3A1B is impossible with distinct digits, so it counts as bad feedback too.
  assign fb_bad = (({1'b0, fb_a} + {1'b0, fb_b}) > 4'd4) ||
                  (fb_a == 3'd3 && fb_b == 3'd1);
  assign inc    = bcd_inc(cand_q);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    guess_d = guess_q;
    rej_d   = rej_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    hist_d  = hist_q;
    case (state_q)
      NEXT: begin
        if (digits_distinct(cand_q) && !rej_q) begin
          state_d = CHECK;
          idx_d   = '0;
        end else begin
          rej_d = 1'b0;
          if (inc[16]) state_d = FAIL;
          else         cand_d  = inc[15:0];
        end
      end
      CHECK: begin
        if (idx_q == cnt_q) begin
          state_d = OFFER;
          guess_d = cand_q;
        end else if (calc_a != hist_sel.a || calc_b != hist_sel.b) begin
          rej_d   = 1'b1;
          state_d = NEXT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OFFER: begin
        if (guess_ready) begin
          turn_d  = turn_q + 1'b1;
          state_d = WAIT_FB;
        end
      end
      WAIT_FB: begin
        if (fb_valid) begin
          if (fb_bad) begin
            state_d = FAIL;
          end else if (fb_a == 3'd4) begin
            state_d = SOLVED;
          end else begin
            for (int i = 0; i < DEPTH; i++)
              if (cnt_q == TW'(i)) hist_d[i] = '{g: guess_q, a: fb_a, b: fb_b};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == TW'(DEPTH - 1)) begin
              state_d = FAIL;
            end else begin
              rej_d   = 1'b1;
              state_d = NEXT;
            end
          end
        end
      end
      default: ;
    endcase
    // Restart overrides whatever the current state decided.
    if (start) begin
      state_d = NEXT;
      cand_d  = '0;
      rej_d   = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      turn_d  = '0;
      hist_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cand_q  <= '0;
      guess_q <= '0;
      rej_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      turn_q  <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      guess_q <= guess_d;
      rej_q   <= rej_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      hist_q  <= hist_d;
    end
  end

  assign guess       = guess_q;
  assign guess_valid = (state_q == OFFER);
  assign busy        = !(state_q inside {IDLE, SOLVED, FAIL});
  assign solved      = (state_q == SOLVED);
  assign fail        = (state_q == FAIL);
  assign turn_count  = turn_q;

endmodule

// File: tb/tb_auto_guesser.sv
// Directed bench for auto_guesser: a DEPTH=8 instance for play/handshake
// scenarios and a DEPTH=2 instance for history exhaustion.
module tb_auto_guesser;
  import game_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       start = 1'b0, start2 = 1'b0;
  logic       guess_ready = 1'b0, fb_valid = 1'b0;
  logic [2:0] fb_a = '0, fb_b = '0;

  guess_t     guess, guess2;
  logic       gv, gv2, busy, busy2, solved, solved2, fail, fail2;
  logic [3:0] turn, turn2;

  int n_chk = 0;
  int n_err = 0;

  always #10 CLK = ~CLK;

  auto_guesser #(.DEPTH(8), .TW(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start),
    .guess(guess), .guess_valid(gv), .guess_ready(guess_ready),
    .fb_valid(fb_valid), .fb_a(fb_a), .fb_b(fb_b),
    .busy(busy), .solved(solved), .fail(fail), .turn_count(turn)
  );

  auto_guesser #(.DEPTH(2), .TW(4)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .start(start2),
    .guess(guess2), .guess_valid(gv2), .guess_ready(guess_ready),
    .fb_valid(fb_valid), .fb_a(fb_a), .fb_b(fb_b),
    .busy(busy2), .solved(solved2), .fail(fail2), .turn_count(turn2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge CLK);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge CLK);
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_offer(input bit sel, input int maxc, input string tag);
    int n;
    n = 0;
    while (!(sel ? gv2 : gv) && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {31'd0, (sel ? gv2 : gv)}, 32'd1);
  endtask

  task automatic accept();
    guess_ready = 1'b1;
    @(negedge CLK);
    guess_ready = 1'b0;
  endtask

  task automatic feedback(input logic [2:0] a, input logic [2:0] b);
    fb_valid = 1'b1; fb_a = a; fb_b = b;
    @(negedge CLK);
    fb_valid = 1'b0; fb_a = '0; fb_b = '0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_valid", {31'd0, gv}, 0);
    chk("rst_guess", guess, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_turn", turn, 0);
    RESET_N = 1'b1;

    // Secret 0123
    pulse_start(0);
    chk("s0123_busy", {31'd0, busy}, 1);
    wait_offer(0, 130, "s0123_offer_to");
    chk("s0123_g1", guess, 16'h0123);
    accept();
    feedback(3'd4, 3'd0);
    chk("s0123_solved", {31'd0, solved}, 1);
    chk("s0123_turn", turn, 1);
    chk("s0123_busy_end", {31'd0, busy}, 0);

    // Secret 4567
    pulse_start(0);
    wait_offer(0, 130, "s4567_to1");
    chk("s4567_g1", guess, 16'h0123);
    accept();
    feedback(3'd0, 3'd0);
    wait_offer(0, 20000, "s4567_to2");
    chk("s4567_g2", guess, 16'h4567);
    accept();
    feedback(3'd4, 3'd0);
    chk("s4567_solved", {31'd0, solved}, 1);
    chk("s4567_turn", turn, 2);

    // Secret 1023
    pulse_start(0);
    wait_offer(0, 130, "s1023_to1");
    chk("s1023_g1", guess, 16'h0123);
    accept();
    feedback(3'd2, 3'd2);
    wait_offer(0, 20000, "s1023_to2");
    chk("s1023_g2", guess, 16'h0132);
    accept();
    feedback(3'd0, 3'd4);
    wait_offer(0, 20000, "s1023_to3");
    chk("s1023_g3", guess, 16'h1023);
    accept();
    feedback(3'd4, 3'd0);
    chk("s1023_solved", {31'd0, solved}, 1);
    chk("s1023_turn", turn, 3);

    // Inconsistent feedback
    pulse_start(0);
    wait_offer(0, 130, "bad23_to");
    accept();
    feedback(3'd2, 3'd3);
    chk("bad23_fail", {31'd0, fail}, 1);
    chk("bad23_turn", turn, 1);
    chk("bad23_busy", {31'd0, busy}, 0);
    pulse_start(0);
    chk("restart_clear", {31'd0, fail}, 0);
    wait_offer(0, 130, "bad31_to");
    accept();
    feedback(3'd3, 3'd1);
    chk("bad31_fail", {31'd0, fail}, 1);
    chk("bad31_solved", {31'd0, solved}, 0);

    // Backpressure, stray feedback, restart in WAIT_FB
    pulse_start(0);
    wait_offer(0, 130, "hs_to");
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("hold_valid", {31'd0, gv}, 1);
      chk("hold_guess", guess, 16'h0123);
    end
    feedback(3'd4, 3'd0);
    chk("stray_fb_valid", {31'd0, gv}, 1);
    chk("stray_fb_solved", {31'd0, solved}, 0);
    chk("stray_fb_turn", turn, 0);
    accept();
    chk("acc_turn", turn, 1);
    chk("acc_valid", {31'd0, gv}, 0);
    start = 1'b1; fb_valid = 1'b1; fb_a = 3'd4; fb_b = 3'd0;
    @(negedge CLK);
    start = 1'b0; fb_valid = 1'b0; fb_a = '0;
    chk("rs_turn", turn, 0);
    chk("rs_solved", {31'd0, solved}, 0);
    chk("rs_busy", {31'd0, busy}, 1);
    wait_offer(0, 130, "rs_to");
    chk("rs_g1", guess, 16'h0123);

    // Asynchronous reset mid-search
    accept();
    feedback(3'd0, 3'd0);
    repeat (50) @(negedge CLK);
    chk("mid_busy_pre", {31'd0, busy}, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_valid", {31'd0, gv}, 0);
    chk("ar_guess", guess, 0);
    chk("ar_turn", turn, 0);
    chk("ar_solved", {31'd0, solved}, 0);
    chk("ar_fail", {31'd0, fail}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("ar_idle", {31'd0, busy}, 0);

    // History exhaustion on the DEPTH=2 instance, secret 9876
    pulse_start(1);
    wait_offer(1, 130, "ex_to1");
    chk("ex_g1", guess2, 16'h0123);
    accept();
    feedback(3'd0, 3'd0);
    chk("ex_fail_early", {31'd0, fail2}, 0);
    wait_offer(1, 20000, "ex_to2");
    chk("ex_g2", guess2, 16'h4567);
    accept();
    feedback(3'd0, 3'd2);
    chk("ex_fail", {31'd0, fail2}, 1);
    chk("ex_turn", turn2, 2);
    chk("ex_busy", {31'd0, busy2}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
